// File: rtl/cpu_control.sv
// cpu_control -- fetch/execute sequencer for a small 8-bit register machine.
//
// Each instruction takes two cycles: FETCH latches the ROM byte into the
// instruction register (IR), and EXEC decodes it and updates the program
// counter (PC). If an instruction at PC 255 falls through, the block stops in
// HALT. Only reset leaves HALT.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               1 = execute; 0 = pause at the next fetch boundary
//   step              (only with CPU_CONTROL_STEP_EN) a rising edge executes
//                     one instruction while run=0
//   rom_address       PC, drives the program ROM address
//   rom_data          instruction byte from the ROM
//   reg0_value        jump target
//   reg3_value        signed operand tested by condition instructions
//   instr             IR
//   imm_we/imm_value  load {2'b00, IR[5:0]} into reg0
//   alu_we/alu_op     reg3 <= reg1 op reg2 (op = IR[2:0])
//   mov_we/mov_src/mov_dst  register copy IR[5:3] -> IR[2:0]
//   jump_taken        condition instruction branching this cycle
//   illegal_op        compute instruction with alu_op 6 or 7
//   halted            block is in HALT
//
// Optional build macro: CPU_CONTROL_STEP_EN adds the single-step input.
module cpu_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
`ifdef CPU_CONTROL_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  input  logic [7:0] reg0_value,
  input  logic [7:0] reg3_value,
  output logic [7:0] instr,
  output logic       imm_we,
  output logic [7:0] imm_value,
  output logic [2:0] alu_op,
  output logic       alu_we,
  output logic [2:0] mov_src,
  output logic [2:0] mov_dst,
  output logic       mov_we,
  output logic       jump_taken,
  output logic       illegal_op,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] pc, pc_nx;
  logic [7:0] ir, ir_nx;
  logic       go;
  logic       zero, neg, cond;

`ifdef CPU_CONTROL_STEP_EN
  logic step_q;
  logic step_pend;

  // A step edge seen while paused is held until FETCH consumes it, so an
  // edge that lands during EXEC still yields exactly one more instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= step;
      if (step && !step_q && !run && state != S_HALT)
        step_pend <= 1'b1;
      else if (state == S_FETCH && go)
        step_pend <= 1'b0;
    end
  end

  assign go = run | step_pend;
`else
  assign go = run;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
    end
  end

  // Condition operand is two's complement.
  assign zero = (reg3_value == 8'h00);
  assign neg  = reg3_value[7];

  always_comb begin
    cond = 1'b0;
    unique case (ir[2:0])
      3'd0: cond = 1'b0;
      3'd1: cond = zero;
      3'd2: cond = neg;
      3'd3: cond = neg | zero;
      3'd4: cond = 1'b1;
      3'd5: cond = !zero;
      3'd6: cond = !neg;
      3'd7: cond = !neg && !zero;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ir_nx      = ir;
    imm_we     = 1'b0;
    alu_we     = 1'b0;
    mov_we     = 1'b0;
    jump_taken = 1'b0;
    illegal_op = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (go) begin
          ir_nx    = rom_data;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (ir[7:6])
          2'b00: imm_we = 1'b1;
          2'b01: begin
            if (ir[2:1] == 2'b11) illegal_op = 1'b1;
            else                  alu_we     = 1'b1;
          end
          2'b10: mov_we     = 1'b1;
          2'b11: jump_taken = cond;
          default: ;
        endcase
        if (jump_taken) begin
          pc_nx    = reg0_value;
          state_nx = S_FETCH;
        end else if (pc == 8'hFF) begin
          state_nx = S_HALT;
        end else begin
          pc_nx    = pc + 8'd1;
          state_nx = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_nx = S_FETCH;
    endcase
  end

  assign rom_address = pc;
  assign instr       = ir;
  assign imm_value   = {2'b00, ir[5:0]};
  assign alu_op      = ir[2:0];
  assign mov_src     = ir[5:3];
  assign mov_dst     = ir[2:0];
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed scenarios plus a randomized
// program run checked against an instruction-level reference model.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst_n, run, step;
  logic [7:0] rom_address, rom_data, reg0_value, reg3_value, instr;
  logic       imm_we, alu_we, mov_we, jump_taken, illegal_op, halted;
  logic [7:0] imm_value;
  logic [2:0] alu_op, mov_src, mov_dst;
  logic [4:0] en;

  logic [7:0] rom [256];
  logic [7:0] mpc;
  bit         mhalt;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_address];
  assign en = {imm_we, alu_we, mov_we, jump_taken, illegal_op};

  cpu_control dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef CPU_CONTROL_STEP_EN
    .step(step),
`endif
    .rom_address(rom_address), .rom_data(rom_data),
    .reg0_value(reg0_value), .reg3_value(reg3_value),
    .instr(instr), .imm_we(imm_we), .imm_value(imm_value),
    .alu_op(alu_op), .alu_we(alu_we), .mov_src(mov_src), .mov_dst(mov_dst),
    .mov_we(mov_we), .jump_taken(jump_taken), .illegal_op(illegal_op),
    .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: which enable fires for an instruction byte, given reg3.
  function automatic logic [4:0] model_en(input logic [7:0] op, input logic [7:0] r3);
    int cls = int'(op) / 64;
    int fn  = int'(op) % 8;
    int s   = int'($signed(r3));
    bit t;
    case (fn)
      0: t = 0;
      1: t = (s == 0);
      2: t = (s < 0);
      3: t = (s <= 0);
      4: t = 1;
      5: t = (s != 0);
      6: t = (s >= 0);
      default: t = (s > 0);
    endcase
    case (cls)
      0: return 5'b10000;
      1: return (fn >= 6) ? 5'b00001 : 5'b01000;
      2: return 5'b00100;
      default: return t ? 5'b00010 : 5'b00000;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc", 32'(rom_address), 32'd0);
    check("rst_ir", 32'(instr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    tick();
    rst_n = 1'b1;
    mpc   = 8'd0;
    mhalt = 1'b0;
  endtask

  // One whole instruction from FETCH, with run=1.
  task automatic exec_one(input logic [7:0] r0, input logic [7:0] r3);
    logic [7:0] op;
    logic [4:0] e;
    check("fetch_pc", 32'(rom_address), 32'(mpc));
    reg0_value = r0;
    reg3_value = r3;
    op = rom[mpc];
    tick();
    e = model_en(op, r3);
    check("ex_instr", 32'(instr), 32'(op));
    check("ex_en", 32'(en), 32'(e));
    check("ex_imm", 32'(imm_value), 32'(op % 8'd64));
    check("ex_aluop", 32'(alu_op), 32'(op % 8'd8));
    check("ex_movsrc", 32'(mov_src), 32'((op / 8'd8) % 8'd8));
    check("ex_movdst", 32'(mov_dst), 32'(op % 8'd8));
    tick();
    if (e[1])              mpc = r0;
    else if (mpc == 8'd255) mhalt = 1'b1;
    else                   mpc = mpc + 8'd1;
    check("next_pc", 32'(rom_address), 32'(mpc));
    check("next_halted", 32'(halted), 32'(mhalt));
    if (mhalt) check("halt_en", 32'(en), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    reg0_value = '0; reg3_value = '0;
    mpc = '0; mhalt = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0]  = 8'h05; rom[1]  = 8'h44; rom[2] = 8'h46; rom[3] = 8'h99;
    rom[4]  = 8'hC4; rom[10] = 8'hC1; rom[11] = 8'hC4;

    #1;
    check("por_pc", 32'(rom_address), 32'd0);
    check("por_ir", 32'(instr), 32'd0);
    check("por_halted", 32'(halted), 32'd0);
    check("por_en", 32'(en), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("idle_pc", 32'(rom_address), 32'd0);
    check("idle_ir", 32'(instr), 32'd0);

    run = 1'b1;
    exec_one(8'd0,  8'd0);    // 0x05 immediate
    exec_one(8'd0,  8'd0);    // 0x44 ADD
    exec_one(8'd0,  8'd0);    // 0x46 illegal
    exec_one(8'd0,  8'd0);    // 0x99 mov 3->1
    exec_one(8'd10, 8'd0);    // 0xC4 jump to 10
    exec_one(8'd0,  8'h80);   // 0xC1, reg3<0: falls through to 11
    exec_one(8'd10, 8'd0);    // 0xC4 back to 10
    exec_one(8'd0,  8'd0);    // 0xC1, reg3=0: jump to 0

    // Drop run during EXEC: instruction completes, then holds at FETCH.
    tick();
    check("drop_ex_en", 32'(en), 32'b10000);
    run = 1'b0;
    tick();
    check("drop_pc", 32'(rom_address), 32'd1);
    repeat (3) tick();
    check("hold_pc", 32'(rom_address), 32'd1);
    check("hold_ir", 32'(instr), 32'h05);
    check("hold_en", 32'(en), 32'd0);
    mpc = 8'd1;
`ifdef CPU_CONTROL_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (8) tick();
    check("step_pc", 32'(rom_address), 32'd2);
    check("step_ir", 32'(instr), 32'h44);
    mpc = 8'd2;
`endif
    run = 1'b1;

    // Reset in the middle of EXEC aborts the instruction.
    tick();
    do_reset();

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int k = 0; k < 300; k++) begin
      if (mhalt) do_reset();
      exec_one(8'($urandom), 8'($urandom));
    end

    // Boundary at PC 255.
    do_reset();
    rom[0] = 8'hC4;
    exec_one(8'd255, 8'd0);
    rom[255] = 8'hC4;
    exec_one(8'd3, 8'd0);     // taken jump at 255
    rom[3] = 8'hC4;
    exec_one(8'd3, 8'd0);     // self loop, no halt
    exec_one(8'd255, 8'd0);
    rom[255] = 8'h00;
    exec_one(8'd0, 8'd0);     // falls through at 255: HALT
    for (int i = 0; i < 6; i++) begin
      run  = i[0];
      step = i[1];
      tick();
    end
    check("halt_hold_pc", 32'(rom_address), 32'd255);
    check("halt_hold_ir", 32'(instr), 32'h00);
    check("halt_hold_flag", 32'(halted), 32'd1);
    check("halt_hold_en", 32'(en), 32'd0);
    rst_n = 1'b0;
    #1;
    check("unhalt_pc", 32'(rom_address), 32'd0);
    check("unhalt_flag", 32'(halted), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 The block SHALL provide the following ports, clock and reset first.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  1 = advance through instructions; 0 = pause at the next fetch boundary
- rom_address  out  8  program counter (PC), driven to the program ROM address input
- rom_data  in  8  instruction byte returned combinationally by the ROM for rom_address
- reg0_value  in  8  current reg0 contents, used as the jump target
- reg3_value  in  8  current reg3 contents, used as the signed condition operand
- instr  out  8  instruction register (IR)
- imm_we  out  1  write imm_value into reg0
- imm_value  out  8  {2'b00, IR[5:0]}
- alu_op  out  3  IR[2:0]: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB
- alu_we  out  1  write the ALU result (reg1 op reg2) into reg3
- mov_src  out  3  IR[5:3]
- mov_dst  out  3  IR[2:0]
- mov_we  out  1  copy register mov_src into register mov_dst
- jump_taken  out  1  a condition instruction is branching this cycle
- illegal_op  out  1  a compute instruction with alu_op 6 or 7 is executing
- halted  out  1  the block is in the HALT state
REQ-002 Reset SHALL be asynchronous and active-low on rst_n; there SHALL be one clock, clk.

Function
REQ-003 The FSM SHALL have three states: FETCH, EXEC and HALT.
REQ-004 In FETCH with run=1, the block SHALL latch rom_data into IR on the clock edge and go to EXEC. With run=0 it SHALL stay in FETCH, and IR and PC SHALL hold.
REQ-005 EXEC SHALL last exactly one cycle regardless of run, so each instruction is atomic and takes 2 cycles.
REQ-006 imm_we, alu_we, mov_we, jump_taken and illegal_op SHALL be asserted only in EXEC, decoded combinationally from IR[7:6]:
- 00: imm_we
- 01: alu_we, or illegal_op instead when alu_op is 6 or 7
- 10: mov_we
- 11: jump_taken when the condition holds
REQ-007 Conditions SHALL be selected by IR[2:0], with reg3_value treated as two's complement: 0 never, 1 =0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
REQ-008 At the end of EXEC, PC SHALL load reg0_value if jump_taken, else PC+1. The state SHALL then go to FETCH.
REQ-009 If EXEC at PC=255 ends without a taken jump, PC SHALL hold at 255 and the state SHALL go to HALT. There is no wrap-around to 0.
REQ-010 A taken jump at PC=255 SHALL go to reg0_value normally.
REQ-011 HALT SHALL be left only by reset. In HALT, halted=1, all enables are 0, and PC and IR hold.
REQ-012 The data outputs (imm_value, alu_op, mov_src, mov_dst, instr) SHALL always reflect IR, and are qualified by their enables.
REQ-013 mov_src equal to mov_dst SHALL still assert mov_we. A jump to the current PC SHALL be permitted and gives an infinite loop, not a halt.

Reset
REQ-014 While rst_n=0: PC=0, IR=0, state FETCH, halted=0, and all enables 0, taking effect immediately without a clock edge.
REQ-015 A reset asserted mid-EXEC SHALL abort the instruction: no enable remains asserted and the PC update is not performed.
REQ-016 After rst_n deasserts, the first fetch SHALL occur on the first rising edge with run=1.

Configuration
REQ-017 With macro CPU_CONTROL_STEP_EN defined, the block SHALL add input step (1 bit).
- A rising edge of step, detected synchronously, SHALL execute exactly one instruction (one FETCH plus one EXEC) while run=0.
- step SHALL be ignored when run=1 or when the block is in HALT.
REQ-018 Without CPU_CONTROL_STEP_EN, the step port SHALL be absent, and pausing and resuming SHALL be controlled by run only.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- Reset, run=1, ROM[0]=0x05 -> cycle 2 (EXEC): imm_we=1, imm_value=0x05; next fetch has rom_address=1.
- IR=0x44 -> alu_we=1, alu_op=4 for one cycle. IR=0x46 -> illegal_op=1, alu_we=0.
- IR=0x99 -> mov_we=1, mov_src=3, mov_dst=1.
- IR=0xC1 with reg3_value=0, reg0_value=0x00 at PC=10 -> jump_taken=1, next rom_address=0. The same with reg3_value=0x80 -> not taken, next rom_address=11.
- PC=255, ROM[255]=0x00 -> after EXEC, halted=1 and rom_address stays 255. Then toggle run and step -> no change. Pulse rst_n low -> rom_address=0, halted=0.
- run dropped during EXEC -> the instruction completes, the block then holds in FETCH with no IR change. With CPU_CONTROL_STEP_EN defined, one step pulse -> exactly one instruction executes.
